// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between single-cycle writeback (A) and a
// multi-cycle unit (B), with a destination scoreboard and a starvation guard for B.
module regfile_write_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            hz_rs1,
    output logic            hz_rs2,
    output logic            hz_rd,
    output logic            we,
    output logic [4:0]      ad3,
    output logic [XLEN-1:0] wd3
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [31:0] pending, pending_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic        force_b, grant_b;

    always_comb begin
        force_b   = b_valid && (starve_cnt == LIMIT);
        grant_b   = b_valid && (!a_valid || force_b);
        a_ready   = !rst && !force_b;
        b_ready   = !rst && grant_b;
        ad3       = grant_b ? b_rd : a_rd;
        wd3       = grant_b ? b_data : a_data;
        // x0 still handshakes; only the physical write is suppressed
        we        = !rst && (grant_b || (a_valid && a_ready)) && (ad3 != 5'd0);
        iss_ready = !rst && !pending[iss_rd];
        hz_rs1    = pending[rs1];
        hz_rs2    = pending[rs2];
        hz_rd     = a_valid && pending[a_rd];
    end

    always_comb begin
        pending_nxt = pending;
        if (b_valid && b_ready)
            pending_nxt[b_rd] = 1'b0;
        // set applied after clear so a same-register collision keeps the reservation
        if (iss_valid && iss_ready && iss_rd != 5'd0)
            pending_nxt[iss_rd] = 1'b1;
        pending_nxt[0] = 1'b0;

        starve_nxt = starve_cnt;
        if (grant_b || !b_valid)
            starve_nxt = 4'd0;
        else if (starve_cnt != LIMIT)
            starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            starve_cnt <= '0;
        end else begin
            pending    <= pending_nxt;
            starve_cnt <= starve_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: vector table for the main handshakes/scoreboard, then hand sequences
// for starvation forcing and reset mid-operation. A small register-file model checks RD1.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, iss_valid;
    logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, iss_ready, hz_rs1, hz_rs2, hz_rd, we;
    logic [4:0]  ad3;
    logic [31:0] wd3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
        .we(we), .ad3(ad3), .wd3(wd3)
    );

    // register file fed by the write port
    logic [31:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    always @(posedge clk) if (we) rf[ad3] <= wd3;
    wire [31:0] rd1 = rf[rs1];

    // {a_ready,b_ready,iss_ready,hz_rs1,hz_rs2,hz_rd,we,ad3,wd3,rd1}
    typedef struct {
        logic        rst, av;  logic [4:0] ard; logic [31:0] ad;
        logic        bv;       logic [4:0] brd; logic [31:0] bd;
        logic        iv;       logic [4:0] ird;
        logic [4:0]  rs1, rs2;
        logic [75:0] exp;
    } vec_t;

    function automatic logic [75:0] ex(input logic ar, br, ir, h1, h2, hd, w,
                                       input logic [4:0] a3, input logic [31:0] d3, r1);
        return {ar, br, ir, h1, h2, hd, w, a3, d3, r1};
    endfunction

    function automatic vec_t mk(input logic r, av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                                input logic iv, input logic [4:0] ird, s1, s2,
                                input logic [75:0] e);
        vec_t v;
        v.rst = r; v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
        v.iv = iv; v.ird = ird; v.rs1 = s1; v.rs2 = s2; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                         input logic iv, input logic [4:0] ird, s1, s2);
        rst = r; a_valid = av; a_rd = ard; a_data = ad; b_valid = bv; b_rd = brd; b_data = bd;
        iss_valid = iv; iss_rd = ird; rs1 = s1; rs2 = s2;
    endtask

    function automatic logic [75:0] outs();
        return {a_ready, b_ready, iss_ready, hz_rs1, hz_rs2, hz_rd, we, ad3, wd3, rd1};
    endfunction

    vec_t vt [12];

    initial begin
        vt[0]  = mk(1,0,0,0,            0,0,0,     0,0,  0,0,  ex(0,0,0,0,0,0,0,0,0,0));
        vt[1]  = mk(0,1,5,32'hDEADBEEF, 0,0,0,     0,0,  5,0,  ex(1,0,1,0,0,0,1,5,32'hDEADBEEF,0));
        vt[2]  = mk(0,1,0,32'h1234,     0,0,0,     0,0,  5,0,  ex(1,0,1,0,0,0,0,0,32'h1234,32'hDEADBEEF));
        vt[3]  = mk(0,0,0,0,            0,0,0,     1,7,  0,7,  ex(1,0,1,0,0,0,0,0,0,0));
        vt[4]  = mk(0,0,0,0,            0,0,0,     1,7,  7,0,  ex(1,0,0,1,0,0,0,0,0,0));
        vt[5]  = mk(0,0,0,0,            1,7,32'h55,0,0,  7,0,  ex(1,1,1,1,0,0,1,7,32'h55,0));
        vt[6]  = mk(0,0,0,0,            0,0,0,     1,9,  7,0,  ex(1,0,1,0,0,0,0,0,0,32'h55));
        vt[7]  = mk(0,0,9,0,            1,9,32'h99,1,9,  0,9,  ex(1,1,0,0,1,0,1,9,32'h99,0));
        vt[8]  = mk(0,0,0,0,            0,0,0,     1,12, 0,9,  ex(1,0,1,0,0,0,0,0,0,0));
        vt[9]  = mk(0,1,12,32'hC0,      0,0,0,     0,0,  12,0, ex(1,0,1,1,0,1,1,12,32'hC0,0));
        vt[10] = mk(0,0,0,0,            1,3,32'h33,1,3,  0,0,  ex(1,1,1,0,0,0,1,3,32'h33,0));
        vt[11] = mk(0,0,0,0,            0,0,0,     0,0,  3,12, ex(1,0,1,1,1,0,0,0,0,32'h33));

        drive(1,0,0,0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].rst, vt[i].av, vt[i].ard, vt[i].ad, vt[i].bv, vt[i].brd, vt[i].bd,
                  vt[i].iv, vt[i].ird, vt[i].rs1, vt[i].rs2);
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(), vt[i].exp);
            @(posedge clk); #1;
        end

        // starvation: pending {3,12}; B forced through on the 5th cycle, then counter restarts
        for (int c = 0; c < 10; c++) begin
            drive(0, 1, 1, 32'hA0 + c, 1, (c <= 4) ? 5'd12 : 5'd3, 32'hBB, 0, 0, 0, 0);
            @(negedge clk);
            check($sformatf("starve_hs%0d", c), {74'd0, a_ready, b_ready},
                  {74'd0, !(c == 4 || c == 9), (c == 4 || c == 9)});
            if (c == 4)
                check("starve_port", {39'd0, we, ad3, wd3}, {39'd0, 1'b1, 5'd12, 32'hBB});
            @(posedge clk); #1;
        end
        drive(0,0,0,0,0,0,0,0,0,12,3);
        @(negedge clk);
        check("starve_clear", {74'd0, hz_rs1, hz_rs2}, 76'd0);
        @(posedge clk); #1;

        // reset mid-operation with rd4 pending and the starvation counter part-way up
        drive(0,0,0,0,0,0,0,1,4,0,0);
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            drive(0,1,1,32'h10,1,4,32'h44,0,0,4,0);
            @(posedge clk); #1;
        end
        drive(1,1,1,32'h10,1,4,32'h44,1,5,4,0);
        @(negedge clk);
        check("rst_outs", {72'd0, we, b_ready, a_ready, iss_ready}, 76'd0);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            drive(0,1,1,32'h10,1,4,32'h44,0,0,4,0);
            @(negedge clk);
            check($sformatf("post_rst%0d", c), {73'd0, hz_rs1, a_ready, b_ready},
                  {73'd0, 1'b0, (c != 4), (c == 4)});
            @(posedge clk); #1;
        end
        drive(0,0,0,0,0,0,0,0,0,0,0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
